note_sequencer: RTL and testbench

Song-playback controller for the level ROM/selector datapath. On `start` it latches the requested level and walks the note address from 0 upward. For each address it waits out the two-stage registered read latency, then releases the fetched note on the next beat strobe from the tempo divider. It sits between the tempo divider and the level selector, and feeds one note per beat to the arrow-spawn logic.

---
 rtl/note_sequencer.sv | 141 ++++++++++++++
 tb/tb_note_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song-playback sequencer: walks note addresses, absorbs the selector read latency and releases one note per beat.
// Optional NOTE_SEQ_END_MARKER_EN: an all-ones captured note ends the song early without being emitted.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no song since reset; waiting for start
// FETCH     | addr presented, counting out the selector read latency
// WAIT_BEAT | note captured in note_hold, waiting for a beat to emit
// DONE      | last note emitted (or end marker hit); start replays
module note_sequencer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 4,
    parameter int SONG_LEN   = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  beat_tick,
    input  logic [1:0]            level_num,
    input  logic [DATA_WIDTH-1:0] note_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            level_sel,
    output logic [DATA_WIDTH-1:0] note_out,
    output logic                  note_valid,
    output logic                  beat_overrun,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0]      CNT_CAPTURE = CNT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_BEAT, DONE} state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic                  pending, pending_nx;
    logic [DATA_WIDTH-1:0] note_hold, note_hold_nx;
    logic [DATA_WIDTH-1:0] note_out_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [1:0]            level_sel_nx;
    logic                  note_valid_nx, beat_overrun_nx;
    logic                  tick_live, beat, is_marker;

    assign tick_live = beat_tick & ~pause;

`ifdef NOTE_SEQ_END_MARKER_EN
    assign is_marker = &note_hold;
`else
    assign is_marker = 1'b0;
`endif

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        pending_nx      = pending;
        note_hold_nx    = note_hold;
        note_out_nx     = note_out;
        addr_nx         = addr;
        level_sel_nx    = level_sel;
        note_valid_nx   = 1'b0;
        beat_overrun_nx = 1'b0;
        beat            = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    addr_nx      = '0;
                    level_sel_nx = level_num;
                    cnt_nx       = '0;
                    pending_nx   = 1'b0;
                    state_nx     = FETCH;
                end
            end
            FETCH: begin
                cnt_nx = cnt + 1'b1;
                // one-deep beat buffer; a second beat in the same fetch is lost
                if (tick_live) begin
                    if (pending) beat_overrun_nx = 1'b1;
                    else         pending_nx      = 1'b1;
                end
                if (cnt == CNT_CAPTURE) begin
                    note_hold_nx = note_in;
                    state_nx     = WAIT_BEAT;
                end
            end
            WAIT_BEAT: begin
                beat = tick_live | pending;
                if (beat) begin
                    pending_nx = 1'b0;
                    if (is_marker) begin
                        state_nx = DONE;
                    end else begin
                        note_out_nx   = note_hold;
                        note_valid_nx = 1'b1;
                        // finishing wins over the increment so addr never wraps
                        if (addr == LAST_ADDR) begin
                            state_nx = DONE;
                        end else begin
                            addr_nx  = addr + 1'b1;
                            cnt_nx   = '0;
                            state_nx = FETCH;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            note_hold    <= '0;
            note_out     <= '0;
            addr         <= '0;
            level_sel    <= '0;
            note_valid   <= 1'b0;
            beat_overrun <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pending      <= pending_nx;
            note_hold    <= note_hold_nx;
            note_out     <= note_out_nx;
            addr         <= addr_nx;
            level_sel    <= level_sel_nx;
            note_valid   <= note_valid_nx;
            beat_overrun <= beat_overrun_nx;
            busy         <= (state_nx == FETCH) || (state_nx == WAIT_BEAT);
            done         <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: each start queues the song's note list, a monitor pops on note_valid.
// Honours NOTE_SEQ_END_MARKER_EN in its reference model.
module tb_note_sequencer;

    localparam int AW  = 6;
    localparam int DW  = 4;
    localparam int SL  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          beat_tick = 1'b0;
    logic [1:0]    level_num = 2'd0;
    logic [DW-1:0] note_in = '0;
    logic [AW-1:0] addr;
    logic [1:0]    level_sel;
    logic [DW-1:0] note_out;
    logic          note_valid, beat_overrun, busy, done;

    note_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SONG_LEN(SL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .beat_tick(beat_tick),
        .level_num(level_num), .note_in(note_in), .addr(addr), .level_sel(level_sel),
        .note_out(note_out), .note_valid(note_valid), .beat_overrun(beat_overrun),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] rom [4][SL];
    logic [DW-1:0] sel_stage = '0;
    int exp_q[$];
    int exp_level = 0;
    int exp_final = 0;
    int emit_cnt = 0;
    int ovr_cnt = 0;
    int song_e0 = 0;
    int song_n = 0;

    // two-register level selector model: ROM register then selector register
    always @(posedge clk) begin
        sel_stage <= rom[level_sel][int'(addr) % SL];
        note_in   <= sel_stage;
    end

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (beat_overrun === 1'b1) ovr_cnt++;
        if (note_valid === 1'b1) begin
            emit_cnt++;
            if (exp_q.size() == 0) check("unexpected_emit", 1, 0);
            else check("note_out", int'(note_out), exp_q.pop_front());
            check("level_sel", int'(level_sel), exp_level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_song(int lvl);
        exp_q.delete();
        exp_final = SL - 1;
        for (int i = 0; i < SL; i++) begin
`ifdef NOTE_SEQ_END_MARKER_EN
            if (rom[lvl][i] == '1) begin
                exp_final = i;
                break;
            end
`endif
            exp_q.push_back(int'(rom[lvl][i]));
        end
        exp_level = lvl;
        song_e0   = emit_cnt;
        song_n    = exp_q.size();
        level_num = 2'(lvl);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic finish_song(int period, int pause_pct, int budget);
        int k = 0;
        int ph = 0;
        while (done !== 1'b1 && k < budget) begin
            beat_tick = (ph == 0);
            ph = (ph + 1) % period;
            pause = ($urandom_range(99) < pause_pct);
            if (busy === 1'b1 && $urandom_range(7) == 0) begin
                start     = 1'b1;
                level_num = 2'($urandom_range(3));
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        beat_tick = 1'b0;
        pause     = 1'b0;
        start     = 1'b0;
        check("song_timeout", int'(k >= budget), 0);
        check("done_high", int'(done), 1);
        check("busy_low", int'(busy), 0);
        check("final_addr", int'(addr), exp_final);
        check("queue_drained", exp_q.size(), 0);
        check("emit_count", emit_cnt - song_e0, song_n);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_level_sel"}, int'(level_sel), 0);
        check({tag, "_note_out"}, int'(note_out), 0);
        check({tag, "_note_valid"}, int'(note_valid), 0);
        check({tag, "_beat_overrun"}, int'(beat_overrun), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int k, e0, o0;
        for (int i = 0; i < SL; i++) begin
            rom[0][i] = DW'($urandom_range(15));
            rom[1][i] = DW'($urandom_range(14));
            rom[3][i] = DW'($urandom_range(14));
        end
        rom[2][0] = 4'd1; rom[2][1] = 4'd2; rom[2][2] = 4'd4; rom[2][3] = 4'd8;
        rom[2][4] = 4'd3; rom[2][5] = 4'd0; rom[2][6] = 4'd6; rom[2][7] = 4'd9;

        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // known song at a steady tempo, including a rest
        start_song(2);
        finish_song(10, 0, 2000);

        // beat during the first fetch is held and released at the earliest slot
        start_song(1);
        o0 = ovr_cnt;
        e0 = emit_cnt;
        beat_tick = 1'b1;
        tick();
        beat_tick = 1'b0;
        k = 1;
        while (emit_cnt == e0 && k < 20) begin
            tick();
            k++;
        end
        check("first_emit_latency", k, LAT + 2);
        check("early_beat_no_overrun", ovr_cnt - o0, 0);
        finish_song(7, 0, 2000);

        // two beats inside one fetch: one dropped, one emitted
        start_song(1);
        e0 = emit_cnt;
        o0 = ovr_cnt;
        beat_tick = 1'b1;
        tick();
        tick();
        beat_tick = 1'b0;
        repeat (8) tick();
        check("overrun_pulses", ovr_cnt - o0, 1);
        check("overrun_single_emit", emit_cnt - e0, 1);
        finish_song(9, 0, 2000);

        // paused beats in WAIT_BEAT are ignored; first beat after pause emits
        start_song(1);
        e0 = emit_cnt;
        repeat (6) tick();
        pause = 1'b1;
        repeat (3) begin
            beat_tick = 1'b1;
            tick();
            beat_tick = 1'b0;
            repeat (3) tick();
        end
        check("paused_no_emit", emit_cnt - e0, 0);
        pause = 1'b0;
        repeat (2) tick();
        check("unpaused_idle_no_emit", emit_cnt - e0, 0);
        beat_tick = 1'b1;
        tick();
        beat_tick = 1'b0;
        check("emit_after_unpause", emit_cnt - e0, 1);
        finish_song(5, 0, 2000);

        // reset in the middle of the fetch for addr 5, then a clean restart
        start_song(1);
        k = 0;
        while (!(note_valid === 1'b1 && addr == AW'(5)) && k < 500) begin
            beat_tick = 1'b1;
            tick();
            k++;
        end
        beat_tick = 1'b0;
        check("reached_addr5", int'(addr), 5);
        rst = 1'b1;
        tick();
        check_all_zero("midsong_reset");
        rst = 1'b0;
        exp_q.delete();
        tick();
        start_song(2);
        check("restart_addr0", int'(addr), 0);
        finish_song(4, 20, 3000);

        // randomized songs, tempos and pause patterns
        for (int s = 0; s < 6; s++) begin
            start_song(int'($urandom_range(3)));
            finish_song(int'($urandom_range(1, 12)), int'($urandom_range(30)), 4000);
        end

        // all-ones note: end marker when enabled, plain chord otherwise
        rom[3][0] = 4'd1;
        rom[3][1] = 4'hF;
        start_song(3);
        finish_song(6, 0, 2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
